// File: rtl/shift_pkg.sv
// Shared encodings for the multi-step rotate sequencer and its shifter.
package shift_pkg;

    localparam int unsigned CTLW = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    // One-hot shifter controls, ordered {fbus, flbus, frbus}
    localparam logic [CTLW-1:0] CTL_NONE = 3'b000;
    localparam logic [CTLW-1:0] CTL_PASS = 3'b100;
    localparam logic [CTLW-1:0] CTL_ROL  = 3'b010;
    localparam logic [CTLW-1:0] CTL_ROR  = 3'b001;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    // Rotate control code for a given direction
    function automatic logic [CTLW-1:0] rot_ctl(input logic d);
        return (d == DIR_R) ? CTL_ROR : CTL_ROL;
    endfunction

endpackage

// File: rtl/shift.sv
// Single-step shifter: pass, rotate left or rotate right; floats when unselected.
module shift #(
    parameter int unsigned W = 8
) (
    input  logic         fbus,
    input  logic         flbus,
    input  logic         frbus,
    input  logic [W-1:0] a,
    output logic         cf,
    output logic [W-1:0] w
);

    // Result word: one-hot select, high-Z when no control is asserted
    assign w = fbus  ? a :
               flbus ? {a[W-2:0], a[W-1]} :
               frbus ? {a[0], a[W-1:1]} :
                       {W{1'bz}};

    // Carry: bit rotated out of the word; no carry on pass
    assign cf = fbus  ? 1'b0 :
                flbus ? a[W-1] :
                frbus ? a[0] :
                        1'bz;

endmodule

// File: rtl/shift_seq.sv
// Multi-step rotate sequencer: issues one single-bit rotate per cycle to the shifter.
module shift_seq
    import shift_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dir,
    input  logic [CW-1:0]   amt,
    input  logic [W-1:0]    din,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    dout,
    output logic            cf,
    output logic [CTLW-1:0] ctl
);

    state_t        state;
    logic [W-1:0]  a;
    logic [CW-1:0] cnt;
    logic          dir_r;
    logic          cf_r;
    logic [W-1:0]  w;
    logic          scf;

    // Shifter driven directly from the registered control code
    shift #(.W(W)) u_shift (
        .fbus  (ctl[2]),
        .flbus (ctl[1]),
        .frbus (ctl[0]),
        .a     (a),
        .cf    (scf),
        .w     (w)
    );

    // Sequencer FSM with registered outputs; ctl/busy track the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            a     <= '0;
            cnt   <= '0;
            dir_r <= DIR_L;
            cf_r  <= 1'b0;
            dout  <= '0;
            cf    <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
            ctl   <= CTL_NONE;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a     <= din;
                        cnt   <= amt;
                        dir_r <= dir;
                        cf_r  <= 1'b0;
                        busy  <= 1'b1;
                        if (amt != '0) begin
                            state <= S_SHIFT;
                            ctl   <= rot_ctl(dir);
                        end else begin
                            state <= S_OUT;
                            ctl   <= CTL_PASS;
                        end
                    end
                end
                S_SHIFT: begin
                    a    <= w;
                    cf_r <= scf;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= S_OUT;
                        ctl   <= CTL_PASS;
                    end else begin
                        ctl   <= rot_ctl(dir_r);
                    end
                end
                S_OUT: begin
                    dout  <= w;
                    cf    <= cf_r;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    ctl   <= CTL_NONE;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    ctl   <= CTL_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: cycle-level reference model plus directed literal checks.
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic [2:0] amt = 3'd0;
    logic [7:0] din = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] dout;
    logic       cf;
    logic [2:0] ctl;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    shift_seq #(.W(8), .CW(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dir   (dir),
        .amt   (amt),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .cf    (cf),
        .ctl   (ctl)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: timeline measured in edges since the accepting edge
    int         t = 0;
    int         e_edge = 0;
    int         m_amt = 0;
    logic       m_dir = 1'b0;
    logic [7:0] m_res = 8'h00;
    logic       m_cf = 1'b0;
    bit         active = 0;
    logic       exp_busy = 1'b0;
    logic       exp_done = 1'b0;
    logic [2:0] exp_ctl = 3'b000;
    logic [7:0] exp_dout = 8'h00;
    logic       exp_cf = 1'b0;

    always @(posedge clk) begin
        logic        prev_busy;
        int          d;
        logic [15:0] dd;
        prev_busy = exp_busy;
        if (rst) begin
            active   = 0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_ctl  = 3'b000;
            exp_dout = 8'h00;
            exp_cf   = 1'b0;
        end else begin
            exp_done = 1'b0;
            exp_busy = 1'b0;
            exp_ctl  = 3'b000;
            if (active) begin
                d = t - e_edge;
                if (d < m_amt) begin
                    exp_busy = 1'b1;
                    exp_ctl  = m_dir ? 3'b001 : 3'b010;
                end else if (d == m_amt) begin
                    exp_busy = 1'b1;
                    exp_ctl  = 3'b100;
                end else begin
                    exp_done = 1'b1;
                    exp_dout = m_res;
                    exp_cf   = m_cf;
                    active   = 0;
                end
            end
            if (start && !prev_busy) begin
                active = 1;
                e_edge = t;
                m_amt  = int'(amt);
                m_dir  = dir;
                dd     = {din, din};
                if (dir) begin
                    dd    = dd >> amt;
                    m_res = dd[7:0];
                    m_cf  = (amt != 3'd0) ? m_res[7] : 1'b0;
                end else begin
                    dd    = dd << amt;
                    m_res = dd[15:8];
                    m_cf  = (amt != 3'd0) ? m_res[0] : 1'b0;
                end
                exp_busy = 1'b1;
                exp_ctl  = (amt == 3'd0) ? 3'b100 : (dir ? 3'b001 : 3'b010);
            end
        end
        t++;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(busy), int'(exp_busy));
            check("done", int'(done), int'(exp_done));
            check("ctl",  int'(ctl),  int'(exp_ctl));
            check("dout", int'(dout), int'(exp_dout));
            check("cf",   int'(cf),   int'(exp_cf));
        end
    end

    // Issue one op from a negedge; returns on the negedge where done is seen
    task automatic run_op(input logic [7:0] v, input logic d, input logic [2:0] n_amt,
                          input logic [7:0] want_dout, input logic want_cf,
                          input int glitch_n, input logic [7:0] gdin, input string nm);
        int  n;
        bit  got;
        din   = v;
        dir   = d;
        amt   = n_amt;
        start = 1'b1;
        n     = 0;
        got   = 0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            start = (glitch_n > 0 && n == glitch_n);
            if (start) din = gdin;
            if (done) got = 1;
        end
        start = 1'b0;
        check({nm, "_seen"}, int'(got), 1);
        check({nm, "_lat"},  n, int'(n_amt) + 2);
        check({nm, "_dout"}, int'(dout), int'(want_dout));
        check({nm, "_cf"},   int'(cf),   int'(want_cf));
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_dout"}, int'(dout), 0);
        check({nm, "_cf"},   int'(cf),   0);
        check({nm, "_done"}, int'(done), 0);
        check({nm, "_busy"}, int'(busy), 0);
        check({nm, "_ctl"},  int'(ctl),  0);
    endtask

    initial begin
        int saw_done;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        check_reset_vals("init_rst");

        // Reset from a random mid-operation state, held 2 cycles
        din = 8'h5A; dir = 1'b0; amt = 3'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rst2");

        run_op(8'h81, 1'b0, 3'd1, 8'h03, 1'b1, 0, 8'h00, "rol1");
        @(negedge clk);
        run_op(8'h01, 1'b1, 3'd3, 8'h20, 1'b0, 0, 8'h00, "ror3");
        @(negedge clk);
        run_op(8'h01, 1'b1, 3'd1, 8'h80, 1'b1, 0, 8'h00, "ror1");
        @(negedge clk);
        run_op(8'hA5, 1'b0, 3'd0, 8'hA5, 1'b0, 0, 8'h00, "amt0");
        @(negedge clk);
        run_op(8'h01, 1'b0, 3'd7, 8'h80, 1'b0, 0, 8'h00, "rol7");
        @(negedge clk);
        run_op(8'h12, 1'b0, 3'd4, 8'h21, 1'b1, 2, 8'hFF, "ignore");
        @(negedge clk);

        // Back-to-back: second start issued in the done cycle
        run_op(8'hC3, 1'b1, 3'd2, 8'hF0, 1'b1, 0, 8'h00, "b2b_a");
        run_op(8'h0F, 1'b0, 3'd2, 8'h3C, 1'b0, 0, 8'h00, "b2b_b");
        @(negedge clk);

        // Reset during the second SHIFT cycle of a 5-step op
        din = 8'hFF; dir = 1'b0; amt = 3'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("midrst");
        saw_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("midrst_nodone", saw_done, 0);
        run_op(8'h3C, 1'b1, 3'd5, 8'hE1, 1'b1, 0, 8'h00, "post_rst");

        repeat (3) @(negedge clk);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
